ext_shift_pipe: RTL and testbench
=================================

EXT_SHIFT_PIPE -- requirements
Module: ext_shift_pipe

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 9, meaning width of the immediate/offset field; legal range 1..OUT_WIDTH.
REQ-002 SHALL have parameter OUT_WIDTH, default 16, meaning datapath word width; legal range 2..32.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  producer offers a field this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts a field this cycle.
REQ-007 SHALL have port in_data  input  IN_WIDTH  raw field.
REQ-008 SHALL have port in_zext  input  1  1 = zero-extend, 0 = sign-extend.
REQ-009 SHALL have port in_lshf1  input  1  1 = shift extended value left by one (LC-3b LSHF1).
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-012 SHALL have port out_data  output  OUT_WIDTH  extended/shifted result.

Function
REQ-013 SHALL accept a field when in_valid && in_ready at a rising edge (push); SHALL release a result when out_valid && out_ready (pop).
REQ-014 SHALL compute ext = in_zext ? zero-pad of in_data to OUT_WIDTH : replicate in_data[IN_WIDTH-1] into bits OUT_WIDTH-1..IN_WIDTH; when IN_WIDTH == OUT_WIDTH, ext = in_data.
REQ-015 SHALL compute result = in_lshf1 ? {ext[OUT_WIDTH-2:0],1'b0} : ext; bit ext[OUT_WIDTH-1] discarded on shift.
REQ-016 SHALL compute result at push time and store it in a 2-entry in-order buffer; in_data/in_zext/in_lshf1 need only be stable in the push cycle.
REQ-017 SHALL have occupancy states EMPTY (0), ONE (1), FULL (2); push only: EMPTY->ONE, ONE->FULL; pop only: FULL->ONE, ONE->EMPTY; push and pop same cycle: occupancy unchanged.
REQ-018 SHALL drive in_ready = 1 in EMPTY and ONE, 0 in FULL; in_ready SHALL be a registered function of state only (no combinational path from out_ready).
REQ-019 SHALL drive out_valid = 1 in ONE and FULL; out_data SHALL be the oldest stored result and SHALL hold steady while out_valid && !out_ready.
REQ-020 SHALL give latency of exactly 1 cycle: a push at edge N makes out_valid high after edge N when the buffer was EMPTY.
REQ-021 SHALL sustain one transfer per cycle when out_ready is held high; in ONE with push+pop, the new result SHALL appear on out_data the next cycle.
REQ-022 SHALL ignore in_valid while in FULL (no overwrite, no loss); SHALL ignore out_ready while EMPTY.
REQ-023 SHALL preserve result order across all wrap-arounds of the internal read/write pointers.

Reset
REQ-024 SHALL, when reset is high at a rising edge, go to EMPTY: out_valid = 0, in_ready = 1, out_data = 0, pointers = 0.
REQ-025 SHALL discard any buffered results when reset asserts mid-stream; a push in the reset cycle SHALL be dropped.
REQ-026 SHALL give reset priority over simultaneous push and pop.

Configuration
REQ-027 SHALL, when macro EXT_SHIFT_OVF_EN is defined, add port out_ovf  output  1, stored per entry, high when in_lshf1 = 1 and ext[OUT_WIDTH-1] != ext[OUT_WIDTH-2] (signed magnitude lost); valid alongside out_data, 0 after reset.
REQ-028 SHALL, without EXT_SHIFT_OVF_EN, omit out_ovf and its storage; all other behaviour identical.

Verification
REQ-029 SHALL cover: IN_WIDTH=9, in_data=9'h1F6, zext=0, lshf1=1, out_ready=1 -> one cycle later out_valid=1, out_data=16'hFFEC.
REQ-030 SHALL cover: IN_WIDTH=9, in_data=9'h1F6, zext=1, lshf1=0 -> out_data=16'h01F6.
REQ-031 SHALL cover: out_ready=0, three consecutive pushes 1,2,3 -> in_ready=0 after second push, third held off; then out_ready=1 -> outputs 1,2,3 in order, no loss or duplication.
REQ-032 SHALL cover: continuous in_valid=1, out_ready=1 for 20 cycles with incrementing data -> 20 results, one per cycle, in order.
REQ-033 SHALL cover: buffer FULL, reset pulsed one cycle -> next cycle out_valid=0, in_ready=1, out_data=0; no stale result later emerges.
REQ-034 SHALL cover (EXT_SHIFT_OVF_EN defined): IN_WIDTH=16, in_data=16'h4000, zext=0, lshf1=1 -> out_data=16'h8000, out_ovf=1; in_data=16'hC000 -> out_data=16'h8000, out_ovf=0.

Source files
------------

// File: rtl/ext_shift_pipe.sv
// rtl/ext_shift_pipe.sv - sign/zero-extend with optional LSHF1, 2-entry in-order output buffer
// Optional EXT_SHIFT_OVF_EN adds a per-entry out_ovf flag for shifted values that lose sign.
module ext_shift_pipe #(
  parameter int IN_WIDTH  = 9,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_zext,
  input  logic                 in_lshf1,
  output logic                 out_valid,
  input  logic                 out_ready,
`ifdef EXT_SHIFT_OVF_EN
  output logic                 out_ovf,
`endif
  output logic [OUT_WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e                 state_q, state_d;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic                 wr_ptr_q;
  logic                 rd_ptr_q;
  logic [OUT_WIDTH-1:0] mem_q [2];
  logic [OUT_WIDTH-1:0] ext;
  logic [OUT_WIDTH-1:0] result_d;
  logic                 push;
  logic                 pop;

  // Handshakes use only registered flags, so in_ready never depends on out_ready.
  assign push = in_valid && in_ready_q;
  assign pop  = out_valid_q && out_ready;

  always_comb begin
    ext = '0;
    if (in_zext) begin
      ext = OUT_WIDTH'(in_data);
    end else begin
      ext = OUT_WIDTH'($signed(in_data));
    end
    result_d = in_lshf1 ? {ext[OUT_WIDTH-2:0], 1'b0} : ext;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (push) state_d = ONE;
      ONE: begin
        if (push && !pop) state_d = FULL;
        else if (pop && !push) state_d = EMPTY;
      end
      FULL: if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
      if (push) begin
        mem_q[wr_ptr_q] <= result_d;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = mem_q[rd_ptr_q];

`ifdef EXT_SHIFT_OVF_EN
  logic ovf_mem_q [2];
  logic ovf_d;

  assign ovf_d = in_lshf1 && (ext[OUT_WIDTH-1] != ext[OUT_WIDTH-2]);

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_mem_q[0] <= 1'b0;
      ovf_mem_q[1] <= 1'b0;
    end else if (push) begin
      ovf_mem_q[wr_ptr_q] <= ovf_d;
    end
  end

  assign out_ovf = ovf_mem_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_ext_shift_pipe.sv
// tb/tb_ext_shift_pipe.sv - directed self-checking bench for ext_shift_pipe
// With EXT_SHIFT_OVF_EN defined, a second 16-bit-input instance exercises out_ovf.
module tb_ext_shift_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  in_data;
  logic        in_zext;
  logic        in_lshf1;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

`ifdef EXT_SHIFT_OVF_EN
  logic        out_ovf;
  logic        w_in_valid, w_in_ready, w_in_lshf1, w_out_valid, w_out_ready, w_out_ovf;
  logic [15:0] w_in_data, w_out_data;

  ext_shift_pipe #(.IN_WIDTH(16), .OUT_WIDTH(16)) dut16 (
    .clk(clk), .reset(reset),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_data(w_in_data), .in_zext(1'b0), .in_lshf1(w_in_lshf1),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_ovf(w_out_ovf), .out_data(w_out_data)
  );
`endif

  ext_shift_pipe #(.IN_WIDTH(9), .OUT_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_zext(in_zext), .in_lshf1(in_lshf1),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef EXT_SHIFT_OVF_EN
    .out_ovf(out_ovf),
`endif
    .out_data(out_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push1(input logic [8:0] d, input logic z, input logic s);
    in_valid = 1'b1; in_data = d; in_zext = z; in_lshf1 = s;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_zext = 1'b0; in_lshf1 = 1'b0; out_ready = 1'b0;
`ifdef EXT_SHIFT_OVF_EN
    w_in_valid = 1'b0; w_in_data = '0; w_in_lshf1 = 1'b0; w_out_ready = 1'b1;
`endif
    tick(); tick();
    reset = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_data", 32'(out_data), 32'h0);
`ifdef EXT_SHIFT_OVF_EN
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
`endif

    // sign-extend and shift, one-cycle latency
    out_ready = 1'b1;
    push1(9'h1F6, 1'b0, 1'b1);
    check("sx_shift_valid", 32'(out_valid), 32'd1);
    check("sx_shift_data", 32'(out_data), 32'hFFEC);
    tick();
    check("sx_shift_drain", 32'(out_valid), 32'd0);

    push1(9'h1F6, 1'b1, 1'b0);
    check("zx_data", 32'(out_data), 32'h01F6);
    tick();
    push1(9'h0AB, 1'b0, 1'b0);
    check("sx_pos_data", 32'(out_data), 32'h00AB);
    tick();
    push1(9'h100, 1'b0, 1'b0);
    check("sx_neg_data", 32'(out_data), 32'hFF00);
    tick();
    push1(9'h100, 1'b0, 1'b1);
    check("sx_neg_shift", 32'(out_data), 32'hFE00);
    tick();
    check("empty_again", 32'(out_valid), 32'd0);

    // backpressure: fill, hold off third push, then drain in order
    out_ready = 1'b0;
    push1(9'd1, 1'b1, 1'b0);
    check("bp_ready_one", 32'(in_ready), 32'd1);
    push1(9'd2, 1'b1, 1'b0);
    check("bp_ready_full", 32'(in_ready), 32'd0);
    check("bp_head1", 32'(out_data), 32'd1);
    in_valid = 1'b1; in_data = 9'd3;
    tick();
    check("bp_still_full", 32'(in_ready), 32'd0);
    check("bp_hold1", 32'(out_data), 32'd1);
    out_ready = 1'b1;
    tick();
    check("bp_pop1_data", 32'(out_data), 32'd2);
    check("bp_pop1_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_pop2_data", 32'(out_data), 32'd3);
    check("bp_pop2_valid", 32'(out_valid), 32'd1);
    tick();
    check("bp_drained", 32'(out_valid), 32'd0);

    // streaming, one transfer per cycle across pointer wraps
    in_zext = 1'b1; in_lshf1 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_data = 9'(i + 16);
      tick();
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_data", 32'(out_data), 32'(i + 16));
    end
    in_valid = 1'b0;
    tick();
    check("stream_drained", 32'(out_valid), 32'd0);

    // reset while full, with simultaneous push and pop offered
    out_ready = 1'b0;
    push1(9'd5, 1'b1, 1'b0);
    push1(9'd6, 1'b1, 1'b0);
    check("pre_rst_full", 32'(in_ready), 32'd0);
    reset = 1'b1; in_valid = 1'b1; in_data = 9'd7; out_ready = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_data", 32'(out_data), 32'h0);
    tick(); tick();
    check("no_stale", 32'(out_valid), 32'd0);
    push1(9'd8, 1'b1, 1'b0);
    check("post_rst_data", 32'(out_data), 32'd8);
    tick();
    check("post_rst_drained", 32'(out_valid), 32'd0);

`ifdef EXT_SHIFT_OVF_EN
    w_in_valid = 1'b1; w_in_data = 16'h4000; w_in_lshf1 = 1'b1;
    tick();
    w_in_data = 16'hC000;
    check("ovf_data_4000", 32'(w_out_data), 32'h8000);
    check("ovf_flag_4000", 32'(w_out_ovf), 32'd1);
    tick();
    w_in_valid = 1'b0;
    check("ovf_data_c000", 32'(w_out_data), 32'h8000);
    check("ovf_flag_c000", 32'(w_out_ovf), 32'd0);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
